// File: rtl/uart_cfg.sv
// Runtime-configurable UART: baud divisor, optional parity, stop length,
// sticky line-error flags, internal loopback and byte-wide FIFOs on both sides.
module uart_cfg_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_wr, w_do_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_do_rd = i_rd && !o_empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module uart_cfg #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_BIT   = 11,
  parameter int FIFO_W     = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                loopback,
  input  logic                rx,
  output logic                tx,
  input  logic                wr_uart,
  input  logic [DBIT-1:0]     w_data,
  input  logic                rd_uart,
  output logic [DBIT-1:0]     r_data,
  output logic                tx_full,
  output logic                tx_empty,
  output logic                rx_full,
  output logic                rx_empty,
  output logic                tx_busy,
  output logic                err_parity,
  output logic                err_frame,
  output logic                err_overrun,
  input  logic                clr_err
);
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          PODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  function automatic logic f_parity(input logic [DBIT-1:0] d);
    return (^d) ^ PODD;
  endfunction

  logic [DVSR_BIT-1:0] r_tick_cnt;
  logic                w_tick;
  logic [1:0]          r_rx_sync;
  logic                w_rx_in;
  rx_state_t           r_rx_state, w_rx_state_nx;
  logic [SW-1:0]       r_rx_s, w_rx_s_nx;
  logic [NW-1:0]       r_rx_n, w_rx_n_nx;
  logic [DBIT-1:0]     r_rx_b, w_rx_b_nx;
  logic                w_rx_done, w_par_ev, w_frm_ev, w_ovr_ev;
  tx_state_t           r_tx_state, w_tx_state_nx;
  logic [SW-1:0]       r_tx_s, w_tx_s_nx;
  logic [NW-1:0]       r_tx_n, w_tx_n_nx;
  logic [DBIT:0]       r_tx_b, w_tx_b_nx;
  logic                r_tx, w_tx_nx, w_tx_pop;
  logic [DBIT-1:0]     w_txf_data;
  logic                w_txf_empty, w_rxf_full;
  logic                r_err_parity, r_err_frame, r_err_overrun;

  // Compare with >= so a divisor lowered below the current count recovers at once
  assign w_tick = (dvsr != '0) && (r_tick_cnt >= dvsr - DVSR_BIT'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_tick_cnt <= '0;
    else if (dvsr == '0 || w_tick)  r_tick_cnt <= '0;
    else                            r_tick_cnt <= r_tick_cnt + DVSR_BIT'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_sync <= 2'b11;
    else       r_rx_sync <= {r_rx_sync[0], rx};
  end

  assign w_rx_in = loopback ? r_tx : r_rx_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_s     <= w_rx_s_nx;
      r_rx_n     <= w_rx_n_nx;
    end
  end

  always_ff @(posedge clk) r_rx_b <= w_rx_b_nx;

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_s_nx     = r_rx_s;
    w_rx_n_nx     = r_rx_n;
    w_rx_b_nx     = r_rx_b;
    w_rx_done     = 1'b0;
    w_par_ev      = 1'b0;
    w_frm_ev      = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!w_rx_in) begin
        w_rx_state_nx = RX_START;
        w_rx_s_nx     = '0;
      end
      RX_START: if (w_tick) begin
        if (r_rx_s == S_MID) begin
          w_rx_s_nx     = '0;
          w_rx_n_nx     = '0;
          w_rx_state_nx = w_rx_in ? RX_IDLE : RX_DATA;
        end else w_rx_s_nx = r_rx_s + SW'(1);
      end
      RX_DATA: if (w_tick) begin
        if (r_rx_s == S_BIT) begin
          w_rx_s_nx = '0;
          w_rx_b_nx = {w_rx_in, r_rx_b[DBIT-1:1]};
          if (r_rx_n == N_LAST) w_rx_state_nx = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          else                  w_rx_n_nx = r_rx_n + NW'(1);
        end else w_rx_s_nx = r_rx_s + SW'(1);
      end
      RX_PARITY: if (w_tick) begin
        if (r_rx_s == S_BIT) begin
          w_rx_s_nx     = '0;
          w_par_ev      = (w_rx_in != f_parity(r_rx_b));
          w_rx_state_nx = RX_STOP;
        end else w_rx_s_nx = r_rx_s + SW'(1);
      end
      RX_STOP: if (w_tick) begin
        if (r_rx_s == S_BIT && !w_rx_in) w_frm_ev = 1'b1;
        if (r_rx_s == S_STOP) begin
          w_rx_done     = 1'b1;
          w_rx_state_nx = RX_IDLE;
        end else w_rx_s_nx = r_rx_s + SW'(1);
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_s     <= w_tx_s_nx;
      r_tx_n     <= w_tx_n_nx;
      r_tx       <= w_tx_nx;
    end
  end

  always_ff @(posedge clk) r_tx_b <= w_tx_b_nx;

  // Parity rides above the data in the shift register, so it lands in bit 0 after DBIT shifts
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_s_nx     = r_tx_s;
    w_tx_n_nx     = r_tx_n;
    w_tx_b_nx     = r_tx_b;
    w_tx_pop      = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_txf_empty) begin
        w_tx_pop      = 1'b1;
        w_tx_b_nx     = {f_parity(w_txf_data), w_txf_data};
        w_tx_s_nx     = '0;
        w_tx_state_nx = TX_START;
      end
      TX_START: if (w_tick) begin
        if (r_tx_s == S_BIT) begin
          w_tx_s_nx     = '0;
          w_tx_n_nx     = '0;
          w_tx_state_nx = TX_DATA;
        end else w_tx_s_nx = r_tx_s + SW'(1);
      end
      TX_DATA: if (w_tick) begin
        if (r_tx_s == S_BIT) begin
          w_tx_s_nx = '0;
          w_tx_b_nx = r_tx_b >> 1;
          if (r_tx_n == N_LAST) w_tx_state_nx = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          else                  w_tx_n_nx = r_tx_n + NW'(1);
        end else w_tx_s_nx = r_tx_s + SW'(1);
      end
      TX_PARITY: if (w_tick) begin
        if (r_tx_s == S_BIT) begin
          w_tx_s_nx     = '0;
          w_tx_state_nx = TX_STOP;
        end else w_tx_s_nx = r_tx_s + SW'(1);
      end
      TX_STOP: if (w_tick) begin
        if (r_tx_s == S_STOP) begin
          if (!w_txf_empty) begin
            w_tx_pop      = 1'b1;
            w_tx_b_nx     = {f_parity(w_txf_data), w_txf_data};
            w_tx_s_nx     = '0;
            w_tx_state_nx = TX_START;
          end else w_tx_state_nx = TX_IDLE;
        end else w_tx_s_nx = r_tx_s + SW'(1);
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
    // Line level follows the state being entered so each bit edge aligns with its tick
    case (w_tx_state_nx)
      TX_START:           w_tx_nx = 1'b0;
      TX_DATA, TX_PARITY: w_tx_nx = w_tx_b_nx[0];
      default:            w_tx_nx = 1'b1;
    endcase
  end

  assign w_ovr_ev = w_rx_done && w_rxf_full && !rd_uart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_parity  <= (r_err_parity  && !clr_err) || w_par_ev;
      r_err_frame   <= (r_err_frame   && !clr_err) || w_frm_ev;
      r_err_overrun <= (r_err_overrun && !clr_err) || w_ovr_ev;
    end
  end

  uart_cfg_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .i_wr(wr_uart), .i_rd(w_tx_pop), .i_data(w_data),
    .o_data(w_txf_data), .o_full(tx_full), .o_empty(w_txf_empty)
  );

  uart_cfg_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .i_wr(w_rx_done), .i_rd(rd_uart), .i_data(r_rx_b),
    .o_data(r_data), .o_full(w_rxf_full), .o_empty(rx_empty)
  );

  assign tx          = r_tx;
  assign tx_empty    = w_txf_empty;
  assign rx_full     = w_rxf_full;
  assign tx_busy     = (r_tx_state != TX_IDLE);
  assign err_parity  = r_err_parity;
  assign err_frame   = r_err_frame;
  assign err_overrun = r_err_overrun;
endmodule

// File: tb/tb_uart_cfg.sv
// Directed/randomized bench for uart_cfg at dvsr=4 (64-cycle bits), 4-deep FIFOs, even parity.
module tb_uart_cfg;
  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int DVSR_BIT = 11;
  localparam int FIFO_W   = 2;
  localparam int BIT_T    = 64;

  logic clk = 1'b0;
  logic reset, loopback, rx, tx, wr_uart, rd_uart, clr_err;
  logic [DVSR_BIT-1:0] dvsr;
  logic [DBIT-1:0] w_data, r_data;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_busy;
  logic err_parity, err_frame, err_overrun;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cfg #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_BIT(DVSR_BIT), .FIFO_W(FIFO_W),
             .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .loopback(loopback), .rx(rx), .tx(tx),
    .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart), .r_data(r_data),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_busy(tx_busy), .err_parity(err_parity), .err_frame(err_frame),
    .err_overrun(err_overrun), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Even parity: the bit that makes the total count of ones even
  function automatic logic ref_par(input logic [DBIT-1:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic send_rx(input logic [DBIT-1:0] d, input logic par, input int stop_low);
    rx = 1'b0;
    cyc(BIT_T);
    for (int i = 0; i < DBIT; i++) begin
      rx = d[i];
      cyc(BIT_T);
    end
    rx = par;
    cyc(BIT_T);
    if (stop_low > 0) begin
      rx = 1'b0;
      cyc(stop_low);
    end
    rx = 1'b1;
    cyc(BIT_T - stop_low);
  endtask

  task automatic wait_rx(input int lim, input string tag);
    int n = 0;
    while (rx_empty && n < lim) begin
      cyc(1);
      n++;
    end
    check(tag, rx_empty, 1'b0);
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    cyc(1);
    rd_uart = 1'b0;
  endtask

  task automatic write_tx(input logic [DBIT-1:0] d);
    wr_uart = 1'b1;
    w_data  = d;
    cyc(1);
    wr_uart = 1'b0;
  endtask

  // Line decoder: waits for a start edge, samples each bit near its centre, returns at mid stop
  task automatic recv_tx(input int lim, output logic [DBIT-1:0] d, output logic p, output logic ok);
    int n = 0;
    logic st;
    d = '0;
    p = 1'b0;
    while (tx !== 1'b0 && n < lim) begin
      cyc(1);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    cyc(32);
    st = tx;
    for (int i = 0; i < DBIT; i++) begin
      cyc(BIT_T);
      d[i] = tx;
    end
    cyc(BIT_T);
    p = tx;
    cyc(BIT_T);
    ok = (st == 1'b0) && (tx == 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DBIT-1:0] d, got;
    logic [DBIT-1:0] exp_q[$];
    logic p, ok, lvl;
    int n, lows, changes;

    reset = 1'b1; dvsr = 11'd4; loopback = 1'b0; rx = 1'b1;
    wr_uart = 1'b0; rd_uart = 1'b0; clr_err = 1'b0; w_data = '0;
    cyc(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_flags", {tx_empty, rx_empty, tx_full, rx_full}, 4'b1100);
    check("rst_err", {err_parity, err_frame, err_overrun}, 3'b000);
    reset = 1'b0;
    cyc(2);

    // Reset in the middle of a 0xA5 frame
    write_tx(8'hA5);
    cyc(150);
    check("t1_midframe_tx", tx, 1'b0);
    check("t1_midframe_busy", tx_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t1_async_tx", tx, 1'b1);
    check("t1_async_busy", tx_busy, 1'b0);
    check("t1_async_empty", {tx_empty, rx_empty}, 2'b11);
    cyc(2);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("t1_quiet", lows, 0);
    check("t1_after_flags", {rx_empty, err_parity, err_frame, err_overrun}, 4'b1000);

    // Loopback: 0xA5 then 0x3C, scope the first frame
    loopback = 1'b1;
    wr_uart = 1'b1; w_data = 8'hA5;
    cyc(1);
    w_data = 8'h3C;
    cyc(1);
    wr_uart = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 20) begin cyc(1); n++; end
    check("t2_start_seen", tx, 1'b0);
    n = 0;
    while (tx === 1'b0 && n < 200) begin cyc(1); n++; end
    check("t2_start_len", (n >= 61 && n <= 64), 1'b1);
    cyc(32);
    got[0] = tx;
    for (int i = 1; i < DBIT; i++) begin cyc(BIT_T); got[i] = tx; end
    check("t2_bits", got, 8'hA5);
    cyc(BIT_T);
    check("t2_parity", tx, ref_par(8'hA5));
    n = 0;
    while (tx !== 1'b1 && n < 100) begin cyc(1); n++; end
    n = 0;
    while (tx === 1'b1 && n < 200) begin cyc(1); n++; end
    check("t2_stop_len", n, BIT_T);
    wait_rx(2500, "t2_wait1");
    check("t2_rd1", r_data, 8'hA5);
    pop_rx();
    wait_rx(2500, "t2_wait2");
    check("t2_rd2", r_data, 8'h3C);
    pop_rx();
    check("t2_err", {err_parity, err_frame, err_overrun}, 3'b000);

    for (int k = 0; k < 3; k++) begin
      d = DBIT'($urandom);
      exp_q.push_back(d);
      wr_uart = 1'b1; w_data = d;
      cyc(1);
    end
    wr_uart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_rx(2500, "t2r_wait");
      check("t2r_data", r_data, exp_q.pop_front());
      pop_rx();
    end
    check("t2r_err", {err_parity, err_frame, err_overrun, rx_empty}, 4'b0001);
    loopback = 1'b0;
    cyc(100);

    // Parity error on 0x55, then clear
    send_rx(8'h55, 1'b1, 0);
    check("t3_avail", rx_empty, 1'b0);
    check("t3_data", r_data, 8'h55);
    check("t3_err", {err_parity, err_frame}, 2'b10);
    pop_rx();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    check("t3_clr", err_parity, 1'b0);
    d = DBIT'($urandom);
    send_rx(d, ref_par(d), 0);
    check("t3r_data", r_data, d);
    check("t3r_err", {err_parity, err_frame}, 2'b00);
    pop_rx();

    // Framing error on 0x0F, then a short glitch
    send_rx(8'h0F, ref_par(8'h0F), 44);
    check("t4_frame", {err_frame, err_parity}, 2'b10);
    check("t4_data", r_data, 8'h0F);
    pop_rx();
    check("t4_empty", rx_empty, 1'b1);
    rx = 1'b0;
    cyc(12);
    rx = 1'b1;
    cyc(200);
    check("t4_glitch", rx_empty, 1'b1);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;

    // RX overrun with a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_rx(DBIT'(i), ref_par(DBIT'(i)), 0);
      if (i == 3) check("t5_notfull", rx_full, 1'b0);
      if (i == 4) check("t5_full", {rx_full, err_overrun}, 2'b10);
    end
    check("t5_overrun", err_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("t5_rd", r_data, DBIT'(i));
      pop_rx();
    end
    check("t5_drained", rx_empty, 1'b1);

    // TX FIFO fill: 6 back-to-back writes, 5 frames expected
    for (int k = 0; k < 6; k++) exp_q.push_back(DBIT'($urandom));
    for (int k = 0; k < 6; k++) begin
      wr_uart = 1'b1; w_data = exp_q[k];
      cyc(1);
      if (k == 3) check("t6_notfull", tx_full, 1'b0);
      if (k == 4) check("t6_full", tx_full, 1'b1);
    end
    wr_uart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      recv_tx(200, got, p, ok);
      check("t6_frame_ok", ok, 1'b1);
      check("t6_frame_data", got, exp_q[k]);
      check("t6_frame_par", p, ref_par(exp_q[k]));
    end
    recv_tx(1500, got, p, ok);
    check("t6_no_sixth", ok, 1'b0);
    check("t6_idle", {tx_busy, tx_empty, tx}, 3'b011);

    // Freeze the tick mid-frame
    write_tx(DBIT'($urandom));
    n = 0;
    while (tx !== 1'b0 && n < 20) begin cyc(1); n++; end
    cyc(300);
    lvl = tx;
    dvsr = '0;
    changes = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (tx !== lvl) changes++;
    end
    check("t6_freeze_hold", changes, 0);
    check("t6_freeze_busy", tx_busy, 1'b1);
    dvsr = 11'd4;
    n = 0;
    while (tx_busy === 1'b1 && n < 1500) begin cyc(1); n++; end
    check("t6_resume_done", {tx_busy, tx}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
